// File: rtl/phy_clk_div_gen.sv
// phy_clk_div_gen: phase-aligned clk/2^(i+1) generator with per-output
// glitch-free gating, rise ticks, frame marker and lock indication.
module phy_clk_div_gen #(
   parameter int NUM_DIV     = 6,
   parameter int LOCK_FRAMES = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               en_i,
   input  logic               sync_req_i,
   input  logic [NUM_DIV-1:0] out_en_i,
   output logic [NUM_DIV-1:0] clk_div_o,
   output logic [NUM_DIV-1:0] tick_rise_o,
   output logic               frame_start_o,
   output logic               locked_o
);

   localparam logic [NUM_DIV-1:0] ONE = NUM_DIV'(1);
   localparam logic [3:0]         LF4 = 4'(LOCK_FRAMES);

   logic [NUM_DIV-1:0] cnt_q, cnt_d;
   logic [NUM_DIV-1:0] gate_q, gate_d;
   logic [NUM_DIV-1:0] div_q, div_d;
   logic [NUM_DIV-1:0] tick_q, tick_d;
   logic               frame_q, frame_d;
   logic [3:0]         lock_cnt_q, lock_cnt_d;
   logic               locked_q, locked_d;

   // Next state: sync restarts, en advances, otherwise hold with ticks low.
   always_comb begin
      cnt_d      = cnt_q;
      gate_d     = gate_q;
      div_d      = div_q;
      tick_d     = '0;
      frame_d    = 1'b0;
      lock_cnt_d = lock_cnt_q;
      locked_d   = locked_q;
      if (sync_req_i) begin
         cnt_d      = '0;
         gate_d     = out_en_i;
         div_d      = '0;
         lock_cnt_d = '0;
         locked_d   = 1'b0;
      end else if (en_i) begin
         cnt_d = cnt_q - ONE;
         // Gate only changes while its output is in a low phase.
         for (int i = 0; i < NUM_DIV; i++) begin
            if (!cnt_d[i]) begin
               gate_d[i] = out_en_i[i];
            end
         end
         div_d   = cnt_d & gate_d;
         tick_d  = div_d & ~div_q;
         frame_d = &cnt_d;
         if (frame_q && (lock_cnt_q != LF4)) begin
            lock_cnt_d = lock_cnt_q + 4'd1;
         end
         if (lock_cnt_d == LF4) begin
            locked_d = 1'b1;
         end
      end
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q      <= '0;
         gate_q     <= '1;
         div_q      <= '0;
         tick_q     <= '0;
         frame_q    <= 1'b0;
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         gate_q     <= gate_d;
         div_q      <= div_d;
         tick_q     <= tick_d;
         frame_q    <= frame_d;
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= locked_d;
      end
   end

   assign clk_div_o     = div_q;
   assign tick_rise_o   = tick_q;
   assign frame_start_o = frame_q;
   assign locked_o      = locked_q;

endmodule

// File: tb/tb_phy_clk_div_gen.sv
// tb_phy_clk_div_gen: scoreboard against a phase-index model plus
// a table of hand-derived vectors and directed corner sequences.
module tb_phy_clk_div_gen;

   localparam int ND = 6;
   localparam int LF = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          en = 1'b0;
   logic          sync_req = 1'b0;
   logic [ND-1:0] out_en = '1;
   logic [ND-1:0] clk_div;
   logic [ND-1:0] tick_rise;
   logic          frame_start;
   logic          locked;

   int checks = 0;
   int errors = 0;

   phy_clk_div_gen #(.NUM_DIV(ND), .LOCK_FRAMES(LF)) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .en_i         (en),
      .sync_req_i   (sync_req),
      .out_en_i     (out_en),
      .clk_div_o    (clk_div),
      .tick_rise_o  (tick_rise),
      .frame_start_o(frame_start),
      .locked_o     (locked)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ND-1:0] div;
      logic [ND-1:0] tick;
      logic          frm;
      logic          lk;
   } exp_t;

   typedef struct {
      int            e;
      logic [ND-1:0] div;
      logic [ND-1:0] tick;
      logic          frm;
      logic          lk;
   } vec_t;

   vec_t tbl[8];
   exp_t sb_q[$];

   logic [ND-1:0] log_div[0:255];
   logic [ND-1:0] log_tick[0:255];
   logic          log_frm[0:255];
   logic          log_lk[0:255];
   int            edge_no = 0;

   // Model state: edges since restart, gates, lock progress.
   int            m_n;
   logic [ND-1:0] m_g, m_div, m_tick;
   logic          m_frm, m_lk;
   int            m_lc;

   task automatic chk(input string nm, input int e,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s edge %0d: got %h expected %h", nm, e, act, exp);
      end
   endtask

   task automatic model_reset();
      m_n = 0; m_g = '1; m_div = '0; m_tick = '0;
      m_frm = 1'b0; m_lk = 1'b0; m_lc = 0;
   endtask

   task automatic model_step(output exp_t x);
      logic [ND-1:0] raw, nd;
      if (sync_req) begin
         m_n = 0; m_div = '0; m_tick = '0; m_frm = 1'b0;
         m_lc = 0; m_lk = 1'b0; m_g = out_en;
      end else if (en) begin
         if (m_frm) begin
            if (m_lc < LF) m_lc++;
            if (m_lc >= LF) m_lk = 1'b1;
         end
         m_n++;
         for (int i = 0; i < ND; i++) begin
            raw[i] = (((m_n - 1) % (2 << i)) < (1 << i));
            if (!raw[i]) m_g[i] = out_en[i];
         end
         nd = raw & m_g;
         m_tick = nd & ~m_div;
         m_div = nd;
         m_frm = (((m_n - 1) % (1 << ND)) == 0);
      end else begin
         m_tick = '0;
         m_frm = 1'b0;
      end
      x.div = m_div; x.tick = m_tick; x.frm = m_frm; x.lk = m_lk;
   endtask

   task automatic edge_step();
      exp_t x;
      model_step(x);
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      edge_no++;
      log_div[edge_no]  = clk_div;
      log_tick[edge_no] = tick_rise;
      log_frm[edge_no]  = frame_start;
      log_lk[edge_no]   = locked;
      x = sb_q.pop_front();
      chk("sb_div", edge_no, 32'(clk_div), 32'(x.div));
      chk("sb_tick", edge_no, 32'(tick_rise), 32'(x.tick));
      chk("sb_frame", edge_no, 32'(frame_start), 32'(x.frm));
      chk("sb_locked", edge_no, 32'(locked), 32'(x.lk));
   endtask

   task automatic restart();
      @(negedge clk);
      reset = 1'b1;
      #1;
      model_reset();
      chk("rst_div", 0, 32'(clk_div), 32'h0);
      chk("rst_lock", 0, 32'(locked), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      edge_no = 0;
   endtask

   task automatic check_table(input string tag);
      for (int k = 0; k < 8; k++) begin
         chk({tag, "_div"}, tbl[k].e, 32'(log_div[tbl[k].e]), 32'(tbl[k].div));
         chk({tag, "_tick"}, tbl[k].e, 32'(log_tick[tbl[k].e]), 32'(tbl[k].tick));
         chk({tag, "_frm"}, tbl[k].e, 32'(log_frm[tbl[k].e]), 32'(tbl[k].frm));
         chk({tag, "_lk"}, tbl[k].e, 32'(log_lk[tbl[k].e]), 32'(tbl[k].lk));
      end
   endtask

   initial begin
      int hi;
      tbl[0] = '{1,  6'h3F, 6'h3F, 1'b1, 1'b0};
      tbl[1] = '{2,  6'h3E, 6'h00, 1'b0, 1'b0};
      tbl[2] = '{3,  6'h3D, 6'h01, 1'b0, 1'b0};
      tbl[3] = '{32, 6'h20, 6'h00, 1'b0, 1'b0};
      tbl[4] = '{33, 6'h1F, 6'h1F, 1'b0, 1'b0};
      tbl[5] = '{64, 6'h00, 6'h00, 1'b0, 1'b0};
      tbl[6] = '{65, 6'h3F, 6'h3F, 1'b1, 1'b0};
      tbl[7] = '{66, 6'h3E, 6'h00, 1'b0, 1'b1};

      model_reset();
      #3;
      chk("reset_div", 0, 32'(clk_div), 32'h0);
      chk("reset_tick", 0, 32'(tick_rise), 32'h0);
      chk("reset_frame", 0, 32'(frame_start), 32'h0);
      chk("reset_locked", 0, 32'(locked), 32'h0);

      // Free run from reset: alignment, periods, lock.
      restart();
      en = 1'b1;
      for (int e = 1; e <= 70; e++) edge_step();
      check_table("run");
      hi = 0;
      for (int e = 1; e <= 64; e++) hi += int'(log_div[e][5]);
      chk("div5_high_cnt", 64, hi, 32);
      chk("locked_hold", 70, 32'(log_lk[70]), 32'h1);

      // Hold for five edges, then continue in phase.
      restart();
      for (int e = 1; e <= 75; e++) begin
         en = !(e >= 20 && e <= 24);
         edge_step();
      end
      en = 1'b1;
      chk("hold_div", 22, 32'(log_div[22]), 32'(log_div[19]));
      chk("hold_tick", 24, 32'(log_tick[24]), 32'h0);
      chk("hold_no_frame65", 65, 32'(log_frm[65]), 32'h0);
      chk("hold_frame70", 70, 32'(log_frm[70]), 32'h1);

      // Sync pulse at edge 40.
      restart();
      for (int e = 1; e <= 108; e++) begin
         sync_req = (e == 40);
         edge_step();
      end
      sync_req = 1'b0;
      chk("sync_div", 40, 32'(log_div[40]), 32'h0);
      chk("sync_lk", 40, 32'(log_lk[40]), 32'h0);
      chk("sync_restart", 41, 32'(log_div[41]), 32'h3F);
      chk("sync_frame", 41, 32'(log_frm[41]), 32'h1);
      chk("sync_lk105", 105, 32'(log_lk[105]), 32'h0);
      chk("sync_lk106", 106, 32'(log_lk[106]), 32'h1);

      // Gate bit 3 off mid-high, back on mid-low.
      restart();
      for (int e = 1; e <= 48; e++) begin
         out_en = (e >= 3 && e <= 28) ? 6'h37 : 6'h3F;
         edge_step();
      end
      out_en = '1;
      hi = 0;
      for (int e = 1; e <= 8; e++) hi += int'(log_div[e][3]);
      chk("gate_full_high", 8, hi, 8);
      hi = 0;
      for (int e = 9; e <= 32; e++) hi += int'(log_div[e][3]) + int'(log_tick[e][3]);
      chk("gate_off", 32, hi, 0);
      hi = 0;
      for (int e = 33; e <= 40; e++) hi += int'(log_div[e][3]);
      chk("gate_reon_high", 40, hi, 8);
      chk("gate_reon_tick", 33, 32'(log_tick[33][3]), 32'h1);

      // Asynchronous reset between edges, then repeat the free run.
      restart();
      for (int e = 1; e <= 50; e++) edge_step();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      chk("async_div", 50, 32'(clk_div), 32'h0);
      chk("async_tick", 50, 32'(tick_rise), 32'h0);
      chk("async_frame", 50, 32'(frame_start), 32'h0);
      chk("async_lk", 50, 32'(locked), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      edge_no = 0;
      for (int e = 1; e <= 70; e++) edge_step();
      check_table("rerun");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
